// File: rtl/sc2110_encode_12to48_module.sv
// -----------------------------------------------------------------------------
// sc2110_encode_12to48_module
//
// Transmit-side SC2110 word builder. It takes a 12-bit pixel stream qualified by
// frame/line/pixel valids and packs four pixels into each 48-bit word. It also
// inserts SOF/SOL/EOL/EOF sync words and, between frames, idle training words.
// The output feeds the 48-bit serializer ahead of the LVDS lanes. It serves as
// a sensor emulator and as the loopback source for the receive chain.
//
// Optional feature (macro SC2110_LINE_HEADER_EN):
//    When defined, the cycle after each SOF/SOL carries a header word
//    {12'h000, 12'h000, frame_cnt, line_cnt} with o_sync=1.
//    When undefined, no header word is sent and the counters do not exist.
//
// Parameters:
//    TRAIN_INTERVAL  idle cycles between training words while i_fvld is low (4..255)
//    TRAIN_CODE      training pixel value, repeated 4 times per training word
//    PAD_CODE        fill value for unfilled slots of a partial final group
//
// Ports:
//    i_clk     in   1   pixel clock, the only clock
//    i_rst     in   1   synchronous reset, active-high
//    i_fvld    in   1   frame valid
//    i_lvld    in   1   line valid
//    i_dvld    in   1   pixel valid; qualified by i_fvld & i_lvld
//    i_data    in  12   pixel value
//    o_dvld    out  1   single-cycle strobe, o_data valid
//    o_data    out 48   packed word; slot n in [12n+11:12n]
//    o_sync    out  1   word is sync/header/training rather than pixels
// -----------------------------------------------------------------------------
module sc2110_encode_12to48_module #(
   parameter int unsigned TRAIN_INTERVAL = 16,
   parameter logic [11:0] TRAIN_CODE     = 12'h050,
   parameter logic [11:0] PAD_CODE       = 12'h000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_fvld,
   input  logic        i_lvld,
   input  logic        i_dvld,
   input  logic [11:0] i_data,
   output logic        o_dvld,
   output logic [47:0] o_data,
   output logic        o_sync
);

   localparam logic [47:0] SOF_WORD   = {12'hAB0, 12'h000, 12'h000, 12'hFFF};
   localparam logic [47:0] SOL_WORD   = {12'h800, 12'h000, 12'h000, 12'hFFF};
   localparam logic [47:0] EOL_WORD   = {12'h9D0, 12'h000, 12'h000, 12'hFFF};
   localparam logic [47:0] EOF_WORD   = {12'hB60, 12'h000, 12'h000, 12'hFFF};
   localparam logic [47:0] TRAIN_WORD = {4{TRAIN_CODE}};
   localparam logic [7:0]  TRAIN_LAST = 8'(TRAIN_INTERVAL - 1);

   typedef enum logic [2:0] {
      WAIT_FRAME,
      FRAME_IDLE,
      LINE,
      FLUSH,
      TAIL
   } state_t;

   state_t      state_reg, state_next;
   logic        fvld_reg;
   logic        first_line_reg, first_line_next;
   logic        eof_pend_reg, eof_pend_next;
   logic        flush_eol_reg, flush_eol_next;   // FLUSH second cycle: send EOL
   logic [1:0]  cnt_reg, cnt_next;               // packer slot for next pixel
   logic [7:0]  train_cnt_reg, train_cnt_next;
   logic        dvld_reg, dvld_next;
   logic        sync_reg, sync_next;
   logic [47:0] data_reg, data_next;
   logic        pack_en;

`ifdef SC2110_LINE_HEADER_EN
   logic        hdr_pend_reg, hdr_pend_next;
   logic [11:0] line_cnt_reg, line_cnt_next;
   logic [11:0] frame_cnt_reg, frame_cnt_next;
`endif

   logic        fvld_rise, fvld_fall, pix_qual, in_frame;
   logic [35:0] slot_bus;     // slots 0..2; slot 3 is taken straight from i_data
   logic [47:0] flush_word;
   logic [47:0] full_word;

   assign fvld_rise = i_fvld & ~fvld_reg;
   assign fvld_fall = ~i_fvld & fvld_reg;
   assign pix_qual  = i_fvld & i_lvld & i_dvld;
   assign in_frame  = (state_reg == FRAME_IDLE) || (state_reg == LINE) ||
                      (state_reg == FLUSH);

   // Packer slots. Only three registers are needed: the fourth pixel completes
   // the word in the same cycle it arrives.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_slot
         logic [11:0] slot_reg;
         always_ff @(posedge i_clk) begin
            if (pack_en && (cnt_reg == 2'(gi))) begin
               slot_reg <= i_data;
            end
         end
         assign slot_bus[gi*12 +: 12]   = slot_reg;
         assign flush_word[gi*12 +: 12] = ({1'b0, cnt_reg} > 3'(gi)) ? slot_reg : PAD_CODE;
      end
   endgenerate

   assign flush_word[47:36] = PAD_CODE;
   assign full_word         = {i_data, slot_bus};

   always_comb begin
      state_next      = state_reg;
      first_line_next = first_line_reg;
      eof_pend_next   = eof_pend_reg;
      flush_eol_next  = flush_eol_reg;
      cnt_next        = cnt_reg;
      train_cnt_next  = 8'd0;
      pack_en         = 1'b0;
      dvld_next       = 1'b0;
      sync_next       = 1'b0;
      data_next       = data_reg;
`ifdef SC2110_LINE_HEADER_EN
      hdr_pend_next   = hdr_pend_reg;
      line_cnt_next   = line_cnt_reg;
      frame_cnt_next  = frame_cnt_reg;
`endif

      // The frame end is remembered until the line closes and EOF can be sent.
      if (fvld_fall && in_frame) begin
         eof_pend_next = 1'b1;
      end

      case (state_reg)
         WAIT_FRAME: begin
            eof_pend_next = 1'b0;
            cnt_next      = 2'd0;
            if (fvld_rise) begin
               state_next      = FRAME_IDLE;
               first_line_next = 1'b1;
            end else if (!i_fvld) begin
               if (train_cnt_reg == TRAIN_LAST) begin
                  dvld_next = 1'b1;
                  sync_next = 1'b1;
                  data_next = TRAIN_WORD;
               end else begin
                  train_cnt_next = train_cnt_reg + 8'd1;
               end
            end
            // i_fvld high without a rising edge (e.g. reset mid-frame): the
            // counter sits at zero and no training is sent.
         end

         FRAME_IDLE: begin
            if (eof_pend_reg || fvld_fall) begin
               dvld_next     = 1'b1;
               sync_next     = 1'b1;
               data_next     = EOF_WORD;
               eof_pend_next = 1'b0;
               state_next    = TAIL;
`ifdef SC2110_LINE_HEADER_EN
               frame_cnt_next = frame_cnt_reg + 12'd1;
`endif
            end else if (pix_qual) begin
               dvld_next       = 1'b1;
               sync_next       = 1'b1;
               data_next       = first_line_reg ? SOF_WORD : SOL_WORD;
               first_line_next = 1'b0;
               pack_en         = 1'b1;
               cnt_next        = 2'd1;
               state_next      = LINE;
`ifdef SC2110_LINE_HEADER_EN
               hdr_pend_next   = 1'b1;
               if (first_line_reg) begin
                  line_cnt_next = 12'd0;
               end
`endif
            end
         end

         LINE: begin
`ifdef SC2110_LINE_HEADER_EN
            // Only possible on the first LINE cycle, where the packer holds one
            // pixel, so no pixel word or EOL can be due in the same cycle.
            if (hdr_pend_reg) begin
               hdr_pend_next = 1'b0;
               dvld_next     = 1'b1;
               sync_next     = 1'b1;
               data_next     = {24'h000000, frame_cnt_reg, line_cnt_reg};
            end
`endif
            if (pix_qual) begin
               pack_en = 1'b1;
               if (cnt_reg == 2'd3) begin
                  dvld_next = 1'b1;
                  sync_next = 1'b0;
                  data_next = full_word;
                  cnt_next  = 2'd0;
               end else begin
                  cnt_next = cnt_reg + 2'd1;
               end
            end else if (!i_lvld || !i_fvld) begin
               // A frame end with the line still open closes the line too.
               if (cnt_reg == 2'd0) begin
                  dvld_next  = 1'b1;
                  sync_next  = 1'b1;
                  data_next  = EOL_WORD;
                  state_next = FRAME_IDLE;
`ifdef SC2110_LINE_HEADER_EN
                  line_cnt_next = line_cnt_reg + 12'd1;
`endif
               end else begin
                  flush_eol_next = 1'b0;
                  state_next     = FLUSH;
               end
            end
         end

         FLUSH: begin
            dvld_next = 1'b1;
            if (!flush_eol_reg) begin
               sync_next      = 1'b0;
               data_next      = flush_word;
               flush_eol_next = 1'b1;
            end else begin
               sync_next      = 1'b1;
               data_next      = EOL_WORD;
               flush_eol_next = 1'b0;
               cnt_next       = 2'd0;
               state_next     = FRAME_IDLE;
`ifdef SC2110_LINE_HEADER_EN
               line_cnt_next  = line_cnt_reg + 12'd1;
`endif
            end
         end

         TAIL: begin
            // A new frame starting right after EOF must not be missed, so the
            // rising edge is taken here rather than back in WAIT_FRAME.
            if (fvld_rise) begin
               state_next      = FRAME_IDLE;
               first_line_next = 1'b1;
            end else begin
               state_next = WAIT_FRAME;
            end
         end

         default: begin
            state_next = WAIT_FRAME;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      // Captured during reset as well, so a reset released while i_fvld is
      // already high is not mistaken for a frame start.
      fvld_reg <= i_fvld;
      if (i_rst) begin
         state_reg      <= WAIT_FRAME;
         first_line_reg <= 1'b0;
         eof_pend_reg   <= 1'b0;
         flush_eol_reg  <= 1'b0;
         cnt_reg        <= 2'd0;
         train_cnt_reg  <= 8'd0;
         dvld_reg       <= 1'b0;
         sync_reg       <= 1'b0;
         data_reg       <= 48'd0;
`ifdef SC2110_LINE_HEADER_EN
         hdr_pend_reg   <= 1'b0;
         line_cnt_reg   <= 12'd0;
         frame_cnt_reg  <= 12'd0;
`endif
      end else begin
         state_reg      <= state_next;
         first_line_reg <= first_line_next;
         eof_pend_reg   <= eof_pend_next;
         flush_eol_reg  <= flush_eol_next;
         cnt_reg        <= cnt_next;
         train_cnt_reg  <= train_cnt_next;
         dvld_reg       <= dvld_next;
         sync_reg       <= sync_next;
         data_reg       <= data_next;
`ifdef SC2110_LINE_HEADER_EN
         hdr_pend_reg   <= hdr_pend_next;
         line_cnt_reg   <= line_cnt_next;
         frame_cnt_reg  <= frame_cnt_next;
`endif
      end
   end

   assign o_dvld = dvld_reg;
   assign o_sync = sync_reg;
   assign o_data = data_reg;

endmodule
